inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction fetch sequencer for the pipelined RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory every cycle, and captures each returned word with its PC into a 2-entry fetch buffer. Delivers instructions to decode over a valid/ready handshake. Handles branch/jump redirects from execute and halts on out-of-range or misaligned fetch addresses.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- MEM_WORDS, 256, instruction memory depth in words; fetch addresses ≥ MEM_WORDS*4 are out of range
- Clk  input  1  sole clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- FetchPC  output  32  byte address to instruction memory (word index = FetchPC[9:2] for 256 words)
- MemInstr  input  32  instruction word returned combinationally for FetchPC in the same cycle
- IF_Valid  output  1  buffer head holds a valid instruction
- IF_Instr  output  32  instruction at buffer head
- IF_PC  output  32  PC of IF_Instr
- ID_Ready  input  1  decode accepts head this cycle
- RedirectValid  input  1  execute requests a fetch redirect (taken branch/jump)
- RedirectPC  input  32  redirect target
- Halted  output  1  fetch stopped on a bad address

## Operation
- FSM states: IDLE, FETCH, HALT.
- IDLE: entered on reset and held for exactly one cycle; no push. Then FETCH.
- FETCH: push when there is space. Space means count<2, or count==2 with a pop in the same cycle. A push writes {FetchPC, MemInstr} at the tail and sets FetchPC ← FetchPC+4, 32-bit wrapping add.
- Pop = IF_Valid & ID_Ready. The head advances; the entry is consumed.
- Bad address means FetchPC[1:0]≠0 or FetchPC ≥ MEM_WORDS*4. Seen in FETCH, it suppresses the push and moves to HALT; FetchPC is held. Entries already buffered still drain normally.
- HALT: Halted=1, no pushes, FetchPC frozen. Only RedirectValid leaves HALT.
- RedirectValid (any state except during Reset) has the highest priority:
  - buffer flushed (count←0, IF_Valid←0), including any pop in the same cycle;
  - FetchPC←RedirectPC;
  - no push that cycle;
  - state←FETCH, Halted←0.
  - The bad-address check applies to RedirectPC on the following cycle.
- Flush versus pop in the same cycle: the pop is still visible to decode (head was valid), and decode must drop it because it also issued the redirect. Buffer state after the edge is empty.
- Simultaneous push and pop at count==2: head advances, new entry written, count stays 2.
- Reset asserted mid-operation immediately forces all reset values, regardless of state or buffer contents.

## Timing
- Reset values: FetchPC=RESET_PC, IF_Valid=0, IF_Instr=0, IF_PC=0, Halted=0, count=0, state=IDLE.
- Fetch-to-decode latency: a word pushed at edge N is at head (IF_Valid=1) after edge N if the buffer was empty.
- Redirect latency: redirect sampled at edge N → FetchPC=RedirectPC after N → target instruction valid after edge N+1.
- First instruction after reset release: valid after the 2nd rising edge (IDLE cycle, then push).
- Throughput: 1 instr/cycle sustained with ID_Ready held high.
- Stall: ID_Ready low fills the buffer in at most 2 cycles; FetchPC then holds and outputs stay stable.
- All outputs registered. FetchPC→MemInstr is a combinational loop-free path; MemInstr is captured only at the clock edge.

## Structure
- Shared package fetch_pkg holds:
  - FSM state enum {IDLE, FETCH, HALT};
  - fetch entry struct {pc[31:0], instr[31:0]};
  - RESET_PC default constant;
  - NOP encoding 32'h0000_0013 for bench use.
- Sub-module fetch_buffer: 2-entry FIFO of fetch entries with push, pop, flush, count[1:0], and head outputs. Flush has priority over push and pop.
- The top-level inst_fetch_ctrl holds the FSM, the PC register, and the bad-address check.

## Test plan
- Reset release, ID_Ready=1, memory word[i]=i → IF_PC sequence 0,4,8,… with IF_Instr 0,1,2; first valid after the 2nd edge, then one per cycle.
- ID_Ready=0 for 5 cycles from steady streaming → buffer holds PC 8 and 12, FetchPC=16 frozen; release → 8, 12, 16 in consecutive cycles with no loss or duplication.
- RedirectValid with RedirectPC=0x40 while count==2 and ID_Ready=1 → buffer empty next cycle, FetchPC=0x40, IF_PC=0x40 valid one cycle later.
- MEM_WORDS=256, streaming past 0x3FC → entry 0x3FC delivered; FetchPC=0x400 triggers HALT, Halted=1, IF_Valid drops after draining; redirect to 0x0 resumes fetch and clears Halted.
- Redirect to 0x42 → HALT on the next cycle, nothing pushed from 0x42.
- Reset asserted mid-stream with count==2 → all outputs return to reset values asynchronously; streaming restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A fetch address is unusable if it is not word aligned or lies past the memory.
    function automatic logic is_bad_addr(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Memory, decode and redirect signals of the fetch sequencer.
interface inst_fetch_ctrl_if;

    logic [31:0] FetchPC;
    logic [31:0] MemInstr;
    logic        IF_Valid;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic        ID_Ready;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic        Halted;

    modport master (
        output FetchPC,
        input  MemInstr,
        output IF_Valid,
        output IF_Instr,
        output IF_PC,
        input  ID_Ready,
        input  RedirectValid,
        input  RedirectPC,
        output Halted
    );

    modport slave (
        input  FetchPC,
        output MemInstr,
        input  IF_Valid,
        input  IF_Instr,
        input  IF_PC,
        output ID_Ready,
        output RedirectValid,
        output RedirectPC,
        input  Halted
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry fetch FIFO kept as a shift pair so the head is always a register.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t e0_r, e1_r, e0_n, e1_n;
    logic [1:0]   cnt_r, cnt_n;
    logic         valid_r, valid_n;
    logic         pop_ok_s, push_ok_s;

    assign pop_ok_s  = pop && (cnt_r != 2'd0);
    assign push_ok_s = push && ((cnt_r != 2'd2) || pop_ok_s);

    // Next entry/count selection; flush overrides any push or pop.
    always_comb begin
        e0_n = e0_r;
        e1_n = e1_r;
        cnt_n = cnt_r;
        if (flush) begin
            cnt_n = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        e0_n = push_entry;
                    end else begin
                        e1_n = push_entry;
                    end
                    cnt_n = cnt_r + 2'd1;
                end
                2'b01: begin
                    e0_n = e1_r;
                    cnt_n = cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        e0_n = push_entry;
                    end else begin
                        e0_n = e1_r;
                        e1_n = push_entry;
                    end
                end
                default: begin
                    cnt_n = cnt_r;
                end
            endcase
        end
        valid_n = (cnt_n != 2'd0);
    end

    // Storage, occupancy and head-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_r    <= '0;
            e1_r    <= '0;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            e0_r    <= e0_n;
            e1_r    <= e1_n;
            cnt_r   <= cnt_n;
            valid_r <= valid_n;
        end
    end

    assign count      = cnt_r;
    assign head_valid = valid_r;
    assign head       = e0_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: PC register, IDLE/FETCH/HALT control, bad-address check
// and redirect handling around a two-entry fetch buffer.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter int          MEM_WORDS = 256
) (
    input  logic               Clk,
    input  logic               Reset,
    inst_fetch_ctrl_if.master  bus
);
    import fetch_pkg::*;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    fetch_state_t state_r, state_n;
    logic [31:0]  pc_r, pc_n;
    logic         halted_r, halted_n;
    logic         push_s, pop_s, space_s, bad_s;
    logic [1:0]   buf_count_s;
    logic         head_valid_s;
    fetch_entry_t head_s;
    fetch_entry_t push_entry_s;

    assign pop_s        = head_valid_s & bus.ID_Ready;
    assign space_s      = (buf_count_s != 2'd2) | pop_s;
    assign bad_s        = is_bad_addr(pc_r, ADDR_LIMIT);
    assign push_entry_s = '{pc: pc_r, instr: bus.MemInstr};

    // Next state, next PC and push decision; a redirect beats everything else.
    always_comb begin
        state_n  = state_r;
        pc_n     = pc_r;
        halted_n = halted_r;
        push_s   = 1'b0;
        if (bus.RedirectValid) begin
            state_n  = FETCH;
            pc_n     = bus.RedirectPC;
            halted_n = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = FETCH;
                end
                FETCH: begin
                    if (bad_s) begin
                        state_n  = HALT;
                        halted_n = 1'b1;
                    end else if (space_s) begin
                        push_s = 1'b1;
                        pc_n   = pc_r + 32'd4;
                    end else begin
                        pc_n = pc_r;
                    end
                end
                HALT: begin
                    halted_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, PC and halt flag registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            pc_r     <= pc_n;
            halted_r <= halted_n;
        end
    end

    fetch_buffer u_buf (
        .clk        (Clk),
        .rst        (Reset),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (bus.RedirectValid),
        .push_entry (push_entry_s),
        .count      (buf_count_s),
        .head_valid (head_valid_s),
        .head       (head_s)
    );

    assign bus.FetchPC  = pc_r;
    assign bus.IF_Valid = head_valid_s;
    assign bus.IF_Instr = head_s.instr;
    assign bus.IF_PC    = head_s.pc;
    assign bus.Halted   = halted_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: queue-based fetch model checked every cycle plus directed literal checks.
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] LIMIT = 32'd1024;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    bit   seen_3fc;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(256)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Instruction memory: word i holds the value i.
    assign bus.MemInstr = {2'b00, bus.FetchPC[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    // Behavioural model: a queue of fetched words, a PC, a halted flag and a post-reset idle flag.
    fetch_entry_t mq[$];
    logic [31:0]  m_pc;
    bit           m_halted;
    bit           m_idle;
    bit           m_pop;
    bit           m_room;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_idle   = 1'b1;
        end else begin
            m_pop = (mq.size() != 0) && bus.ID_Ready;
            if (bus.RedirectValid) begin
                mq.delete();
                m_pc     = bus.RedirectPC;
                m_halted = 1'b0;
                m_idle   = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
            end else if (m_halted) begin
                if (m_pop) void'(mq.pop_front());
            end else if ((m_pc % 4 != 0) || (m_pc >= LIMIT)) begin
                m_halted = 1'b1;
                if (m_pop) void'(mq.pop_front());
            end else begin
                m_room = (mq.size() < 2) || m_pop;
                if (m_pop) void'(mq.pop_front());
                if (m_room) begin
                    mq.push_back('{pc: m_pc, instr: m_pc / 4});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("FetchPC", bus.FetchPC, m_pc);
        chk1("IF_Valid", bus.IF_Valid, mq.size() != 0);
        chk1("Halted", bus.Halted, m_halted);
        if (mq.size() != 0) begin
            chk("IF_PC", bus.IF_PC, mq[0].pc);
            chk("IF_Instr", bus.IF_Instr, mq[0].instr);
        end
        if (bus.IF_Valid && bus.ID_Ready && bus.IF_PC == 32'h0000_03FC) seen_3fc = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.RedirectValid = 1'b1;
        bus.RedirectPC    = target;
        step();
        bus.RedirectValid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_FetchPC"}, bus.FetchPC, 32'h0000_0000);
        chk1({tag, "_IF_Valid"}, bus.IF_Valid, 1'b0);
        chk({tag, "_IF_Instr"}, bus.IF_Instr, 32'h0000_0000);
        chk({tag, "_IF_PC"}, bus.IF_PC, 32'h0000_0000);
        chk1({tag, "_Halted"}, bus.Halted, 1'b0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        seen_3fc          = 1'b0;
        rst               = 1'b1;
        bus.ID_Ready      = 1'b1;
        bus.RedirectValid = 1'b0;
        bus.RedirectPC    = 32'h0000_0000;
        repeat (2) step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Streaming from reset: IDLE cycle, then one instruction per cycle.
        step();
        chk1("idle_no_valid", bus.IF_Valid, 1'b0);
        step();
        chk1("first_valid", bus.IF_Valid, 1'b1);
        chk("first_pc", bus.IF_PC, 32'h0000_0000);
        chk("first_fetchpc", bus.FetchPC, 32'h0000_0004);
        step();
        chk("stream_pc1", bus.IF_PC, 32'h0000_0004);
        chk("stream_instr1", bus.IF_Instr, 32'h0000_0001);
        step();
        chk("stream_pc2", bus.IF_PC, 32'h0000_0008);
        chk("stream_instr2", bus.IF_Instr, 32'h0000_0002);

        // Stall for five cycles, then release.
        bus.ID_Ready = 1'b0;
        repeat (5) step();
        chk("stall_head", bus.IF_PC, 32'h0000_0008);
        chk("stall_fetchpc", bus.FetchPC, 32'h0000_0010);
        bus.ID_Ready = 1'b1;
        step();
        chk("release_pc12", bus.IF_PC, 32'h0000_000C);
        step();
        chk("release_pc16", bus.IF_PC, 32'h0000_0010);

        // Redirect with a full buffer and decode ready.
        redirect(32'h0000_0040);
        chk1("redir_flush", bus.IF_Valid, 1'b0);
        chk("redir_fetchpc", bus.FetchPC, 32'h0000_0040);
        step();
        chk1("redir_valid", bus.IF_Valid, 1'b1);
        chk("redir_pc", bus.IF_PC, 32'h0000_0040);
        chk("redir_instr", bus.IF_Instr, 32'h0000_0010);

        // Run off the end of memory.
        redirect(32'h0000_03F0);
        repeat (8) step();
        chk1("oor_halted", bus.Halted, 1'b1);
        chk1("oor_drained", bus.IF_Valid, 1'b0);
        chk("oor_fetchpc", bus.FetchPC, 32'h0000_0400);
        chk1("oor_last_delivered", seen_3fc, 1'b1);
        redirect(32'h0000_0000);
        chk1("resume_halted", bus.Halted, 1'b0);
        chk("resume_fetchpc", bus.FetchPC, 32'h0000_0000);
        step();
        chk("resume_pc", bus.IF_PC, 32'h0000_0000);

        // Misaligned redirect target halts without pushing.
        redirect(32'h0000_0042);
        chk("mis_fetchpc", bus.FetchPC, 32'h0000_0042);
        chk1("mis_not_yet_halted", bus.Halted, 1'b0);
        step();
        chk1("mis_halted", bus.Halted, 1'b1);
        chk1("mis_no_push", bus.IF_Valid, 1'b0);
        step();
        chk("mis_frozen", bus.FetchPC, 32'h0000_0042);

        // Asynchronous reset in the middle of a stalled, full buffer.
        redirect(32'h0000_0080);
        repeat (3) step();
        bus.ID_Ready = 1'b0;
        repeat (3) step();
        chk1("pre_reset_valid", bus.IF_Valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        bus.ID_Ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        chk1("restart_valid", bus.IF_Valid, 1'b1);
        chk("restart_pc", bus.IF_PC, 32'h0000_0000);
        step();
        chk("restart_pc4", bus.IF_PC, 32'h0000_0004);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
